// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// One pipeline boundary register for an in-order integer pipeline. It captures
// the upstream slot (valid, instruction, PC, delay-slot flag, exception code),
// merges any exception raised at this boundary, precomputes PC+4 / PC+8 for
// the downstream stage, and counts how long a valid entry has been stalled.
//
// Edge priority: reset > flush > hold (en=0) > load.
//
// Ports
//   clk          in   1        single clock, rising edge
//   reset        in   1        asynchronous active-low reset
//   en           in   1        advance enable; 0 holds the stage
//   flush        in   1        replace the stage contents with a bubble
//   valid_in     in   1        upstream slot holds a real instruction
//   instr_in     in   INSTR_W  upstream instruction
//   pc_in        in   PC_W     upstream PC
//   exc_in       in   EXC_W    exception code from earlier stages (0 = none)
//   exc_local    in   EXC_W    exception detected at this boundary (0 = none)
//   bj_in        in   1        upstream instruction is in a branch delay slot
//   valid_out    out  1        registered valid
//   instr_out    out  INSTR_W  registered instruction, 0 when excepted/invalid
//   pc_out       out  PC_W     registered PC
//   pc4_out      out  PC_W     registered PC + 4 (wrapping)
//   pc8_out      out  PC_W     registered PC + 8 (wrapping)
//   exc_out      out  EXC_W    registered effective exception code
//   bj_out       out  1        registered delay-slot flag
//   exc_pending  out  1        valid_out and a non-zero exc_out
//   stall_cnt    out  CNT_W    consecutive hold cycles of a valid entry
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int PC_W             = 32,
    parameter int INSTR_W          = 32,
    parameter int EXC_W            = 5,
    parameter int CNT_W            = 8,
    parameter int KEEP_PC_ON_FLUSH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [EXC_W-1:0]   exc_in,
    input  logic [EXC_W-1:0]   exc_local,
    input  logic               bj_in,
    output logic               valid_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc4_out,
    output logic [PC_W-1:0]    pc8_out,
    output logic [EXC_W-1:0]   exc_out,
    output logic               bj_out,
    output logic               exc_pending,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [PC_W-1:0]    PC_INC4   = PC_W'(32'd4);
    localparam logic [PC_W-1:0]    PC_INC8   = PC_W'(32'd8);
    localparam logic [PC_W-1:0]    PC_ZERO   = {PC_W{1'b0}};
    localparam logic [INSTR_W-1:0] INSTR_NOP = {INSTR_W{1'b0}};
    localparam logic [EXC_W-1:0]   EXC_NONE  = {EXC_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // Effective exception for an incoming slot: an invalid slot carries none,
    // and an older (upstream) exception outranks one raised here.
    function automatic logic [EXC_W-1:0] eff_exc(
        input logic             valid,
        input logic [EXC_W-1:0] upstream,
        input logic [EXC_W-1:0] local_code
    );
        logic [EXC_W-1:0] code;
        if (!valid) begin
            code = EXC_NONE;
        end else if (upstream != EXC_NONE) begin
            code = upstream;
        end else begin
            code = local_code;
        end
        return code;
    endfunction

    // Saturating increment for the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    logic               valid_r;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc4_r;
    logic [PC_W-1:0]    pc8_r;
    logic [EXC_W-1:0]   exc_r;
    logic               bj_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    logic               valid_nxt_s;
    logic [INSTR_W-1:0] instr_nxt_s;
    logic [PC_W-1:0]    pc_nxt_s;
    logic [PC_W-1:0]    pc4_nxt_s;
    logic [PC_W-1:0]    pc8_nxt_s;
    logic [EXC_W-1:0]   exc_nxt_s;
    logic               bj_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_nxt_s;

    logic [EXC_W-1:0]   load_exc_s;
    logic [PC_W-1:0]    load_pc4_s;
    logic [PC_W-1:0]    load_pc8_s;

    // Values the stage would capture on a load edge (PC sums wrap naturally).
    always_comb begin
        load_exc_s = eff_exc(valid_in, exc_in, exc_local);
        load_pc4_s = pc_in + PC_INC4;
        load_pc8_s = pc_in + PC_INC8;
    end

    // Next-state selection: flush beats hold, hold beats load.
    always_comb begin
        valid_nxt_s     = valid_r;
        instr_nxt_s     = instr_r;
        pc_nxt_s        = pc_r;
        pc4_nxt_s       = pc4_r;
        pc8_nxt_s       = pc8_r;
        exc_nxt_s       = exc_r;
        bj_nxt_s        = bj_r;
        stall_cnt_nxt_s = stall_cnt_r;

        if (flush) begin
            valid_nxt_s     = 1'b0;
            instr_nxt_s     = INSTR_NOP;
            exc_nxt_s       = EXC_NONE;
            stall_cnt_nxt_s = CNT_ZERO;
            // The bubble may keep the killed slot's PC so a later restart
            // or EPC capture still sees where the pipeline stood.
            if (KEEP_PC_ON_FLUSH != 0) begin
                pc_nxt_s  = pc_in;
                pc4_nxt_s = load_pc4_s;
                pc8_nxt_s = load_pc8_s;
                bj_nxt_s  = bj_in;
            end else begin
                pc_nxt_s  = PC_ZERO;
                pc4_nxt_s = PC_ZERO;
                pc8_nxt_s = PC_ZERO;
                bj_nxt_s  = 1'b0;
            end
        end else if (!en) begin
            // Hold: contents unchanged; only a valid entry accumulates stall time.
            if (valid_r) begin
                stall_cnt_nxt_s = sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_nxt_s = stall_cnt_r;
            end
        end else begin
            valid_nxt_s     = valid_in;
            pc_nxt_s        = pc_in;
            pc4_nxt_s       = load_pc4_s;
            pc8_nxt_s       = load_pc8_s;
            bj_nxt_s        = bj_in;
            exc_nxt_s       = load_exc_s;
            stall_cnt_nxt_s = CNT_ZERO;
            // An excepted or empty slot must not execute downstream: send a nop.
            if (valid_in && (load_exc_s == EXC_NONE)) begin
                instr_nxt_s = instr_in;
            end else begin
                instr_nxt_s = INSTR_NOP;
            end
        end
    end

    // Stage register with asynchronous clear; nothing survives reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r     <= 1'b0;
            instr_r     <= INSTR_NOP;
            pc_r        <= PC_ZERO;
            pc4_r       <= PC_ZERO;
            pc8_r       <= PC_ZERO;
            exc_r       <= EXC_NONE;
            bj_r        <= 1'b0;
            stall_cnt_r <= CNT_ZERO;
        end else begin
            valid_r     <= valid_nxt_s;
            instr_r     <= instr_nxt_s;
            pc_r        <= pc_nxt_s;
            pc4_r       <= pc4_nxt_s;
            pc8_r       <= pc8_nxt_s;
            exc_r       <= exc_nxt_s;
            bj_r        <= bj_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    // Output drive: registered values, plus the derived pending flag.
    always_comb begin
        valid_out   = valid_r;
        instr_out   = instr_r;
        pc_out      = pc_r;
        pc4_out     = pc4_r;
        pc8_out     = pc8_r;
        exc_out     = exc_r;
        bj_out      = bj_r;
        stall_cnt   = stall_cnt_r;
        exc_pending = valid_r && (exc_r != EXC_NONE);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic        valid_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [4:0]  exc_in;
    logic [4:0]  exc_local;
    logic        bj_in;

    // Instance with the default flush behaviour (PC kept)
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic [31:0] pc8_out;
    logic [4:0]  exc_out;
    logic        bj_out;
    logic        exc_pending;
    logic [7:0]  stall_cnt;

    // Instance whose flush bubble clears the PC fields
    logic        valid_out_z;
    logic [31:0] instr_out_z;
    logic [31:0] pc_out_z;
    logic [31:0] pc4_out_z;
    logic [31:0] pc8_out_z;
    logic [4:0]  exc_out_z;
    logic        bj_out_z;
    logic        exc_pending_z;
    logic [7:0]  stall_cnt_z;

    int vectors;
    int miscompares;

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .exc_in(exc_in), .exc_local(exc_local), .bj_in(bj_in),
        .valid_out(valid_out), .instr_out(instr_out), .pc_out(pc_out),
        .pc4_out(pc4_out), .pc8_out(pc8_out), .exc_out(exc_out),
        .bj_out(bj_out), .exc_pending(exc_pending), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(0)) dut_z (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .exc_in(exc_in), .exc_local(exc_local), .bj_in(bj_in),
        .valid_out(valid_out_z), .instr_out(instr_out_z), .pc_out(pc_out_z),
        .pc4_out(pc4_out_z), .pc8_out(pc8_out_z), .exc_out(exc_out_z),
        .bj_out(bj_out_z), .exc_pending(exc_pending_z), .stall_cnt(stall_cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},   64'(valid_out),   64'd0);
        check({tag, ".instr"},   64'(instr_out),   64'd0);
        check({tag, ".pc"},      64'(pc_out),      64'd0);
        check({tag, ".pc4"},     64'(pc4_out),     64'd0);
        check({tag, ".pc8"},     64'(pc8_out),     64'd0);
        check({tag, ".exc"},     64'(exc_out),     64'd0);
        check({tag, ".bj"},      64'(bj_out),      64'd0);
        check({tag, ".pend"},    64'(exc_pending), 64'd0);
        check({tag, ".stall"},   64'(stall_cnt),   64'd0);
        check({tag, ".z_pc"},    64'(pc_out_z),    64'd0);
        check({tag, ".z_valid"}, 64'(valid_out_z), 64'd0);
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [4:0] ei, input logic [4:0] el,
                         input logic bj);
        en = e; flush = f; valid_in = v; instr_in = ins; pc_in = pc;
        exc_in = ei; exc_local = el; bj_in = bj;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_1000, 5'd0, 5'd0, 1'b1);

        // Reset state, before and across clock edges
        #2;
        check_all_zero("reset_pre_edge");
        step();
        check_all_zero("reset_held");

        // Release reset between edges; first edge after release loads
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h2408_0005, 32'h0000_3000, 5'd0, 5'd0, 1'b0);
        step();
        check("basic.valid", 64'(valid_out),   64'd1);
        check("basic.instr", 64'(instr_out),   64'h2408_0005);
        check("basic.pc",    64'(pc_out),      64'h3000);
        check("basic.pc4",   64'(pc4_out),     64'h3004);
        check("basic.pc8",   64'(pc8_out),     64'h3008);
        check("basic.exc",   64'(exc_out),     64'd0);
        check("basic.pend",  64'(exc_pending), 64'd0);
        check("basic.bj",    64'(bj_out),      64'd0);
        check("basic.stall", 64'(stall_cnt),   64'd0);

        // Local exception only
        drive(1'b1, 1'b0, 1'b1, 32'h8C01_0000, 32'h0000_3004, 5'd0, 5'd4, 1'b1);
        step();
        check("exc_local.instr", 64'(instr_out),   64'd0);
        check("exc_local.exc",   64'(exc_out),     64'd4);
        check("exc_local.pend",  64'(exc_pending), 64'd1);
        check("exc_local.bj",    64'(bj_out),      64'd1);
        check("exc_local.pc8",   64'(pc8_out),     64'h300C);

        // Upstream exception wins over local
        drive(1'b1, 1'b0, 1'b1, 32'h8C01_0000, 32'h0000_3008, 5'd6, 5'd4, 1'b0);
        step();
        check("exc_prio.exc",   64'(exc_out),     64'd6);
        check("exc_prio.instr", 64'(instr_out),   64'd0);
        check("exc_prio.pend",  64'(exc_pending), 64'd1);

        // Invalid slot drops its exception and instruction
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_300C, 5'd6, 5'd4, 1'b0);
        step();
        check("invalid.valid", 64'(valid_out),   64'd0);
        check("invalid.instr", 64'(instr_out),   64'd0);
        check("invalid.exc",   64'(exc_out),     64'd0);
        check("invalid.pend",  64'(exc_pending), 64'd0);
        check("invalid.pc",    64'(pc_out),      64'h300C);

        // PC wrap
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 5'd0, 5'd0, 1'b0);
        step();
        check("wrap.pc",  64'(pc_out),  64'hFFFF_FFFC);
        check("wrap.pc4", 64'(pc4_out), 64'h0000_0000);
        check("wrap.pc8", 64'(pc8_out), 64'h0000_0004);

        // Hold while invalid: counter stays 0
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_5000, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA, 32'h0000_6000, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check("hold_invalid.stall", 64'(stall_cnt), 64'd0);
        check("hold_invalid.pc",    64'(pc_out),    64'h5000);

        // Long stall of a valid entry: counts to 255 and saturates
        drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_4000, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h8765_4321, 32'h0000_7000, 5'd3, 5'd1, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            step();
            check($sformatf("stall.cnt%0d", i), 64'(stall_cnt), (i > 255) ? 64'd255 : 64'(i));
        end
        check("stall.instr", 64'(instr_out), 64'h1234_5678);
        check("stall.pc",    64'(pc_out),    64'h4000);
        check("stall.pc4",   64'(pc4_out),   64'h4004);
        check("stall.exc",   64'(exc_out),   64'd0);
        check("stall.bj",    64'(bj_out),    64'd0);
        check("stall.valid", 64'(valid_out), 64'd1);

        // Next load clears the counter and brings in new data
        drive(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 32'h0000_4100, 5'd0, 5'd0, 1'b0);
        step();
        check("after_stall.stall", 64'(stall_cnt), 64'd0);
        check("after_stall.instr", 64'(instr_out), 64'h0BAD_F00D);
        check("after_stall.pc",    64'(pc_out),    64'h4100);

        // Flush during a stall, with en=0
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("pre_flush.stall", 64'(stall_cnt), 64'd3);
        drive(1'b0, 1'b1, 1'b1, 32'h2408_0005, 32'h0000_3010, 5'd7, 5'd2, 1'b1);
        step();
        check("flush.valid", 64'(valid_out),   64'd0);
        check("flush.instr", 64'(instr_out),   64'd0);
        check("flush.exc",   64'(exc_out),     64'd0);
        check("flush.pend",  64'(exc_pending), 64'd0);
        check("flush.pc",    64'(pc_out),      64'h3010);
        check("flush.pc4",   64'(pc4_out),     64'h3014);
        check("flush.pc8",   64'(pc8_out),     64'h3018);
        check("flush.bj",    64'(bj_out),      64'd1);
        check("flush.stall", 64'(stall_cnt),   64'd0);
        check("flush_z.valid", 64'(valid_out_z), 64'd0);
        check("flush_z.instr", 64'(instr_out_z), 64'd0);
        check("flush_z.exc",   64'(exc_out_z),   64'd0);
        check("flush_z.pc",    64'(pc_out_z),    64'd0);
        check("flush_z.pc4",   64'(pc4_out_z),   64'd0);
        check("flush_z.pc8",   64'(pc8_out_z),   64'd0);
        check("flush_z.bj",    64'(bj_out_z),    64'd0);
        check("flush_z.stall", 64'(stall_cnt_z), 64'd0);

        // Hold after flush: entry invalid so counter stays 0
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        step();
        check("post_flush_hold.stall", 64'(stall_cnt), 64'd0);
        check("post_flush_hold.pc",    64'(pc_out),    64'h3010);

        // Asynchronous reset in the middle of a hold
        drive(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 32'h0000_8000, 5'd0, 5'd9, 1'b1);
        step();
        check("pre_reset.exc",  64'(exc_out),     64'd9);
        check("pre_reset.pend", 64'(exc_pending), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        step();
        step();
        check("pre_reset.stall", 64'(stall_cnt), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        drive(1'b1, 1'b0, 1'b1, 32'h5555_5555, 32'h0000_9000, 5'd0, 5'd0, 1'b0);
        step();
        check_all_zero("async_reset_edge");

        // Release and load once more
        #2;
        reset = 1'b1;
        step();
        check("post_reset.valid", 64'(valid_out), 64'd1);
        check("post_reset.instr", 64'(instr_out), 64'h5555_5555);
        check("post_reset.pc4",   64'(pc4_out),   64'h9004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 32, meaning width of the PC fields.
REQ-002 Parameter INSTR_W, default 32, meaning width of the instruction field.
REQ-003 Parameter EXC_W, default 5, meaning width of the exception-code field; 0 means no exception.
REQ-004 Parameter CNT_W, default 8, meaning width of the stall counter.
REQ-005 Parameter KEEP_PC_ON_FLUSH, default 1, meaning a flush bubble carries pc_in/bj_in when 1 and zeros when 0.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  advance enable; 0 = stall (hold).
REQ-009 flush  input  1  insert bubble (exception/eret/branch kill).
REQ-010 valid_in  input  1  upstream slot holds a real instruction.
REQ-011 instr_in  input  INSTR_W  upstream instruction.
REQ-012 pc_in  input  PC_W  upstream PC.
REQ-013 exc_in  input  EXC_W  exception code carried from upstream stages.
REQ-014 exc_local  input  EXC_W  exception detected at this boundary.
REQ-015 bj_in  input  1  upstream instruction sits in a branch delay slot.
REQ-016 valid_out  output  1  registered valid.
REQ-017 instr_out  output  INSTR_W  registered instruction, 0 (nop) when excepted or invalid.
REQ-018 pc_out, pc4_out, pc8_out  output  PC_W each  registered pc_in, pc_in+4, pc_in+8.
REQ-019 exc_out  output  EXC_W  registered effective exception code.
REQ-020 bj_out  output  1  registered delay-slot flag.
REQ-021 exc_pending  output  1  combinational: valid_out AND exc_out != 0.
REQ-022 stall_cnt  output  CNT_W  consecutive held cycles of a valid entry.

Function
REQ-023 Update priority per edge SHALL be: reset > flush > (en=0 hold) > load.
REQ-024 Load (flush=0, en=1) SHALL register valid_out=valid_in, pc_out=pc_in, bj_out=bj_in, pc4_out=pc_in+4, pc8_out=pc_in+8.
REQ-025 PC arithmetic SHALL be modulo 2^PC_W (wrap, no carry out).
REQ-026 On load the effective exception SHALL be: 0 if valid_in=0; else exc_in if exc_in!=0; else exc_local (upstream code has priority).
REQ-027 On load instr_out SHALL be instr_in when effective exception is 0 and valid_in=1, else 0.
REQ-028 Flush SHALL register valid_out=0, instr_out=0, exc_out=0 regardless of en.
REQ-029 On flush with KEEP_PC_ON_FLUSH=1, pc_out/pc4_out/pc8_out/bj_out SHALL load as in REQ-024; with 0 they SHALL be cleared to 0.
REQ-030 Hold (en=0, flush=0) SHALL keep every registered output unchanged.
REQ-031 stall_cnt SHALL increment on each hold edge while valid_out=1, saturating at 2^CNT_W-1.
REQ-032 stall_cnt SHALL clear to 0 on any load or flush edge, and SHALL not change on hold while valid_out=0.
REQ-033 Latency input-to-output SHALL be exactly one clock on load; no combinational path from inputs to registered outputs.

Reset
REQ-034 reset low SHALL immediately (asynchronously) drive all registered outputs and stall_cnt to 0.
REQ-035 Reset release SHALL take effect at the next rising edge; first edge with reset high follows REQ-023.
REQ-036 Reset asserted mid-stall or mid-flush SHALL discard held state; no entry survives reset.

Verification
REQ-037 en=1, valid_in=1, instr_in=0x2408_0005, pc_in=0x0000_3000, exc 0 -> next cycle instr_out=0x2408_0005, pc4_out=0x3004, pc8_out=0x3008, valid_out=1.
REQ-038 Load exc_in=0, exc_local=4, instr_in=0x8C01_0000 -> instr_out=0, exc_out=4, exc_pending=1; repeat with exc_in=6, exc_local=4 -> exc_out=6.
REQ-039 Valid entry held en=0 for 300 cycles, CNT_W=8 -> stall_cnt counts 1..255 then stays 255; next load -> stall_cnt=0, new data.
REQ-040 flush=1 with en=0, pc_in=0x3010, bj_in=1, KEEP_PC_ON_FLUSH=1 -> valid_out=0, instr_out=0, exc_out=0, pc_out=0x3010, bj_out=1; with parameter 0 -> pc_out=0, bj_out=0.
REQ-041 pc_in=0xFFFF_FFFC load -> pc4_out=0x0000_0000, pc8_out=0x0000_0004.
REQ-042 reset driven low between clock edges during a hold -> all outputs 0 immediately, before the next edge.
